// File: rtl/cnt_irq_master_if.sv
// Register-bus and event-port signals shared by cnt_irq_master (master side)
// and the counter block / event consumer (slave side).
interface cnt_irq_master_if;
  logic        cs;
  logic        rw;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_id;
  logic [31:0] evt_data;

  modport master (
    output cs, rw, addr, wdata, evt_valid, evt_id, evt_data,
    input  rdata, evt_ready
  );

  modport slave (
    input  cs, rw, addr, wdata, evt_valid, evt_id, evt_data,
    output rdata, evt_ready
  );
endinterface

// File: rtl/cnt_irq_master.sv
// Interrupt-servicing bus initiator: edge-detects irq lines, reads the winning channel's count,
// emits it as an event and, when CNT_IRQ_REARM_EN is defined, re-arms the channel with a write.
module cnt_irq_master #(
  parameter int unsigned NCH         = 10,
  parameter logic [7:0]  CNT_BASE    = 8'h40,
  parameter logic [7:0]  CTRL_BASE   = 8'h00,
  parameter int unsigned ADDR_STRIDE = 4,
  parameter int unsigned RD_LAT      = 1,
  parameter logic [31:0] REARM_VAL   = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    irq_i,
  cnt_irq_master_if.master  bus,
  output logic [NCH-1:0]    ovr_o,
  output logic              busy_o
);

`ifdef CNT_IRQ_REARM_EN
  typedef enum logic [2:0] {StIdle, StRd, StWait, StCap, StWr} state_e;
`else
  typedef enum logic [2:0] {StIdle, StRd, StWait, StCap} state_e;
  // Re-arm settings have no effect without the write phase.
  logic unused_rearm_cfg;
  assign unused_rearm_cfg = ^{CTRL_BASE, REARM_VAL};
`endif

  state_e         state_q, state_d;
  logic [NCH-1:0] irq_q, pend_q, pend_d, ovr_q, rise, clr;
  logic [3:0]     id_q, id_d, lowest;
  logic [2:0]     wcnt_q, wcnt_d;
  logic [31:0]    data_q, data_d;
  logic [7:0]     offset;

  assign rise   = irq_i & ~irq_q;
  assign offset = 8'(32'(id_q) * ADDR_STRIDE);
  // A new edge in the same cycle as the service clear keeps the channel pending.
  assign pend_d = (pend_q & ~clr) | rise;

  always_comb begin
    lowest = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[i]) lowest = 4'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    wcnt_d        = wcnt_q;
    data_d        = data_q;
    clr           = '0;
    bus.cs        = 1'b0;
    bus.rw        = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.evt_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          id_d    = lowest;
          state_d = StRd;
        end
      end
      StRd: begin
        bus.cs   = 1'b1;
        bus.addr = CNT_BASE + offset;
        clr      = NCH'(1) << id_q;
        wcnt_d   = '0;
        state_d  = StWait;
      end
      StWait: begin
        if (wcnt_q == 3'(RD_LAT - 1)) begin
          data_d  = bus.rdata;
          state_d = StCap;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      StCap: begin
        bus.evt_valid = 1'b1;
        if (bus.evt_ready) begin
`ifdef CNT_IRQ_REARM_EN
          state_d = StWr;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef CNT_IRQ_REARM_EN
      StWr: begin
        bus.cs    = 1'b1;
        bus.rw    = 1'b1;
        bus.addr  = CTRL_BASE + offset;
        bus.wdata = REARM_VAL;
        state_d   = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign bus.evt_id   = id_q;
  assign bus.evt_data = data_q;
  assign ovr_o        = ovr_q;
  assign busy_o       = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      irq_q   <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      id_q    <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_i;
      pend_q  <= pend_d;
      ovr_q   <= rise & pend_q;
      id_q    <= id_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_cnt_irq_master.sv
// Bench for cnt_irq_master: two instances (RD_LAT=1 and RD_LAT=3) with bus-slave models and a
// scoreboard of expected bus accesses and events.
module tb_cnt_irq_master;
  localparam int unsigned NCH = 10;
`ifdef CNT_IRQ_REARM_EN
  localparam bit RearmEn = 1'b1;
`else
  localparam bit RearmEn = 1'b0;
`endif

  typedef struct packed {logic rw; logic [7:0] addr; logic [31:0] wdata;} bus_t;
  typedef struct packed {logic [3:0] id; logic [31:0] data;} evt_t;

  logic           clk = 1'b0;
  logic           rst1, rst3;
  logic [NCH-1:0] irq1, irq3, ovr1, ovr3;
  logic           busy1, busy3;

  always #5 clk = ~clk;

  cnt_irq_master_if bus1 ();
  cnt_irq_master_if bus3 ();

  cnt_irq_master #(.NCH(NCH), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .irq_i(irq1), .bus(bus1.master), .ovr_o(ovr1), .busy_o(busy1)
  );
  cnt_irq_master #(.NCH(NCH), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .irq_i(irq3), .bus(bus3.master), .ovr_o(ovr3), .busy_o(busy3)
  );

  // Bus slave models: count values per channel, rdata valid only RD_LAT cycles after the read.
  logic [31:0] cnt1 [16];
  logic [31:0] cnt3 [16];
  logic [3:0]  rv1 = '0, rv3 = '0;
  logic [31:0] rd1 [4];
  logic [31:0] rd3 [4];

  function automatic logic [3:0] chan_of(input logic [7:0] a);
    return 4'((a - 8'h40) >> 2);
  endfunction

  always @(posedge clk) begin
    rv1 <= {rv1[2:0], bus1.cs & ~bus1.rw};
    rv3 <= {rv3[2:0], bus3.cs & ~bus3.rw};
    rd1[0] <= cnt1[chan_of(bus1.addr)];
    rd3[0] <= cnt3[chan_of(bus3.addr)];
    for (int i = 1; i < 4; i++) begin
      rd1[i] <= rd1[i-1];
      rd3[i] <= rd3[i-1];
    end
  end
  assign bus1.rdata = rv1[0] ? rd1[0] : 32'hDEAD_BEEF;
  assign bus3.rdata = rv3[2] ? rd3[2] : 32'hDEAD_BEEF;

  int   checks = 0;
  int   errors = 0;
  bus_t exp_bus1[$];
  bus_t exp_bus3[$];
  evt_t exp_evt1[$];
  int   cyc = 0;
  int   cs_cyc[$];
  int   busy_cnt1 = 0;
  int   ovr_cnt [NCH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ovr_total();
    int s = 0;
    for (int i = 0; i < NCH; i++) s += ovr_cnt[i];
    return s;
  endfunction

  task automatic push_bus1(input int ch, input bit with_wr);
    exp_bus1.push_back(bus_t'{rw: 1'b0, addr: 8'h40 + 8'(ch * 4), wdata: 32'h0});
    if (with_wr) exp_bus1.push_back(bus_t'{rw: 1'b1, addr: 8'(ch * 4), wdata: 32'h1});
  endtask

  task automatic push_svc1(input int ch);
    push_bus1(ch, RearmEn);
    exp_evt1.push_back(evt_t'{id: 4'(ch), data: cnt1[ch]});
  endtask

  task automatic push_bus3(input int ch, input bit with_wr);
    exp_bus3.push_back(bus_t'{rw: 1'b0, addr: 8'h40 + 8'(ch * 4), wdata: 32'h0});
    if (with_wr) exp_bus3.push_back(bus_t'{rw: 1'b1, addr: 8'(ch * 4), wdata: 32'h1});
  endtask

  task automatic drive1(input logic [NCH-1:0] v);
    @(posedge clk);
    #1 irq1 = v;
  endtask

  task automatic drive3(input logic [NCH-1:0] v);
    @(posedge clk);
    #1 irq3 = v;
  endtask

  task automatic wait_drain1(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_bus1.size() != 0 || exp_evt1.size() != 0 || busy1) && n < budget);
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_valid1(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus1.evt_valid && n < budget);
    chk(tag, 64'(bus1.evt_valid), 64'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor for the RD_LAT=1 instance: every bus access and every event is scoreboarded.
  initial forever begin
    @(negedge clk);
    if (!rst1) begin
      if (busy1) busy_cnt1++;
      for (int i = 0; i < NCH; i++) if (ovr1[i]) ovr_cnt[i]++;
      if (bus1.cs) begin
        cs_cyc.push_back(cyc);
        chk("bus1_expected", 64'(exp_bus1.size() != 0), 64'd1);
        if (exp_bus1.size() != 0) begin
          bus_t e;
          e = exp_bus1.pop_front();
          chk("bus1_access", 64'({bus1.rw, bus1.addr, bus1.wdata}), 64'(e));
        end
      end
      if (bus1.evt_valid && bus1.evt_ready) begin
        chk("evt1_expected", 64'(exp_evt1.size() != 0), 64'd1);
        if (exp_evt1.size() != 0) begin
          evt_t e;
          e = exp_evt1.pop_front();
          chk("evt1_payload", 64'({bus1.evt_id, bus1.evt_data}), 64'(e));
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst3 && bus3.cs) begin
      chk("bus3_expected", 64'(exp_bus3.size() != 0), 64'd1);
      if (exp_bus3.size() != 0) begin
        bus_t e;
        e = exp_bus3.pop_front();
        chk("bus3_access", 64'({bus3.rw, bus3.addr, bus3.wdata}), 64'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int n;
    rst1 = 1'b1;
    rst3 = 1'b1;
    irq1 = '0;
    irq3 = '0;
    bus1.evt_ready = 1'b1;
    bus3.evt_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cnt1[i] = 32'h1000_0000 + 32'(i) * 32'h111;
      cnt3[i] = 32'h3000_0000 + 32'(i) * 32'h222;
    end
    cnt1[3] = 32'h0000_00A5;
    cnt1[9] = 32'h1234_5678;
    cnt3[1] = 32'hCAFE_0001;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus", 64'({bus1.cs, bus1.rw, bus1.addr, bus1.wdata}), 64'd0);
    chk("rst_evt", 64'({bus1.evt_valid, bus1.evt_id, bus1.evt_data}), 64'd0);
    chk("rst_ovr_busy", 64'({ovr1, busy1}), 64'd0);
    @(posedge clk);
    #1 rst1 = 1'b0;

    // Single event on channel 3 with edge-to-RD timing
    busy_cnt1 = 0;
    drive1(10'h008);
    push_svc1(3);
    @(negedge clk);
    chk("edge_T_idle", 64'(busy1), 64'd0);
    @(negedge clk);
    chk("edge_T1_idle", 64'(busy1), 64'd0);
    @(negedge clk);
    chk("edge_T2_rd", 64'({busy1, bus1.cs, bus1.rw, bus1.addr}), 64'({3'b110, 8'h4C}));
    wait_drain1("single_drain", 40);
    chk("single_busy_cycles", 64'(busy_cnt1), RearmEn ? 64'd4 : 64'd3);
    drive1(10'h000);

    // Priority: channels 2 and 7 together, back-to-back service
    for (int i = 0; i < NCH; i++) ovr_cnt[i] = 0;
    cs_cyc.delete();
    drive1(10'h084);
    push_svc1(2);
    push_svc1(7);
    wait_drain1("prio_drain", 60);
    chk("prio_no_ovr", 64'(ovr_total()), 64'd0);
    chk("prio_cs_count", 64'(cs_cyc.size()), RearmEn ? 64'd4 : 64'd2);
    chk("prio_span", 64'(cs_cyc[cs_cyc.size() - 1] - cs_cyc[0]), RearmEn ? 64'd8 : 64'd4);
    drive1(10'h000);

    // Backpressure on channel 9 (highest channel)
    bus1.evt_ready = 1'b0;
    drive1(10'h200);
    push_svc1(9);
    wait_valid1("bp_valid_seen", 20);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", 64'({bus1.evt_valid, bus1.cs, bus1.evt_id, bus1.evt_data}),
          64'({1'b1, 1'b0, 4'd9, 32'h1234_5678}));
    end
    @(posedge clk);
    #1 bus1.evt_ready = 1'b1;
    wait_drain1("bp_drain", 20);

    // Overrun on channel 5 while channel 0 is held in the event stage
    drive1(10'h000);
    bus1.evt_ready = 1'b0;
    for (int i = 0; i < NCH; i++) ovr_cnt[i] = 0;
    drive1(10'h001);
    push_svc1(0);
    wait_valid1("ovr_hold_valid", 20);
    drive1(10'h021);
    push_svc1(5);
    drive1(10'h001);
    drive1(10'h021);
    drive1(10'h001);
    repeat (2) @(negedge clk);
    chk("ovr5_count", 64'(ovr_cnt[5]), 64'd1);
    chk("ovr_others", 64'(ovr_total() - ovr_cnt[5]), 64'd0);
    @(posedge clk);
    #1 bus1.evt_ready = 1'b1;
    wait_drain1("ovr_drain", 60);
    drive1(10'h021);
    push_svc1(5);
    wait_drain1("ovr_second_event", 40);
    chk("ovr5_after", 64'(ovr_cnt[5]), 64'd1);

    // RD_LAT=3 instance: read latency, then reset during WAIT
    @(posedge clk);
    #1 rst3 = 1'b0;
    drive3(10'h002);
    push_bus3(1, RearmEn);
    repeat (6) @(negedge clk);
    chk("lat3_before", 64'(bus3.evt_valid), 64'd0);
    @(negedge clk);
    chk("lat3_valid", 64'({bus3.evt_valid, bus3.evt_id, bus3.evt_data}),
        64'({1'b1, 4'd1, 32'hCAFE_0001}));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy3 && n < 20);
    chk("lat3_done", 64'(busy3), 64'd0);

    drive3(10'h010);
    push_bus3(4, 1'b0);
    drive3(10'h000);
    @(posedge clk);
    #1;
    drive3(10'h040);
    @(posedge clk);
    #1 irq3 = '0;
    rst3 = 1'b1;
    @(negedge clk);
    chk("pre_rst_wait", 64'({busy3, bus3.cs, bus3.evt_valid}), 64'({1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    chk("rst_wait_out", 64'({bus3.cs, bus3.rw, bus3.evt_valid, busy3, ovr3}), 64'd0);
    @(posedge clk);
    #1 rst3 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'({busy3, bus3.cs}), 64'd0);
    end
    chk("rst_bus3_drained", 64'(exp_bus3.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnt_irq_master.md
# cnt_irq_master

Register-bus initiator that services the counter block's interrupt lines. It edge-detects up to NCH interrupt inputs and arbitrates among pending channels by fixed priority. For each serviced channel it issues a bus read of that channel's count register and delivers the value on a valid/ready event port. It then optionally re-arms the channel with a bus write. It drives the same cs/rw/addr/wdata/rdata register bus that the counter top responds on, from the master side.

## Interface
Parameters:
- NCH, 10, number of interrupt channels (1..16).
- CNT_BASE, 8'h40, bus address of channel 0 count register.
- CTRL_BASE, 8'h00, bus address of channel 0 control register.
- ADDR_STRIDE, 4, address step between channels.
- RD_LAT, 1, cycles from read-request cycle to valid rdata (1..4).
- REARM_VAL, 32'h0000_0001, wdata written to the control register on re-arm.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- irq  in  NCH  counter interrupt lines, level, bit i = channel i.
- cs  out  1  bus chip select, one-cycle pulse per access.
- rw  out  1  1 = write, 0 = read; valid only while cs=1.
- addr  out  8  bus address.
- wdata  out  32  write data.
- rdata  in  32  read data, valid RD_LAT cycles after the read cs cycle.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_id  out  4  serviced channel index.
- evt_data  out  32  count value read.
- ovr  out  NCH  one-cycle pulse: rising edge on an already-pending channel.
- busy  out  1  FSM not in IDLE.

## Operation
- Edge detect: irq_q registers irq each cycle and resets to 0. A rising edge (irq[i]=1 and irq_q[i]=0) sets pend[i]. A line already high when reset releases counts as an edge.
- Overrun: an edge on channel i while pend[i]=1 pulses ovr[i]. pend[i] stays 1 and the event is lost.
- Simultaneous set and clear on the same channel in one cycle: the set wins.
- FSM states: IDLE, RD, WAIT, CAP, WR.
- IDLE: if pend≠0, latch id = lowest set index and go to RD.
- RD: cs=1, rw=0, addr=CNT_BASE+id·ADDR_STRIDE (8-bit truncating add). Clear pend[id]. Go to WAIT.
- WAIT: count RD_LAT cycles. On the last one, capture rdata into evt_data and go to CAP.
- CAP: evt_valid=1. evt_id and evt_data are held stable until evt_valid&evt_ready. Then go to WR (or IDLE, see Configuration).
- WR: cs=1, rw=1, addr=CTRL_BASE+id·ADDR_STRIDE, wdata=REARM_VAL. Go to IDLE.
- Only one bus access is outstanding at a time. Edges arriving during service are still captured in pend.
- Reset values: cs=0, rw=0, addr=0, wdata=0, evt_valid=0, evt_id=0, evt_data=0, ovr=0, busy=0, pend=0, state IDLE.
- Reset mid-operation: the FSM aborts at the next edge, cs drops, evt_valid drops, and no partial write is issued.

## Timing
- Edge at cycle T: pend set at T+1, FSM in RD at T+2.
- Read data sampled at RD+RD_LAT. evt_valid asserted the cycle after that.
- Minimum service with ready held high: 1 (IDLE) + 1 (RD) + RD_LAT (WAIT) + 1 (CAP) + 1 (WR) cycles. That is 5 cycles with RD_LAT=1.
- cs is high for exactly one cycle per access. addr, rw and wdata are valid in that same cycle.
- Back-to-back channels: the next RD begins 2 cycles after WR.

## Configuration
- CNT_IRQ_REARM_EN defined: the WR state exists, and each event ends with the control-register write.
- Not defined: WR is removed and CAP returns directly to IDLE on handshake. No write cycle is ever issued, so rw is constant 0 and wdata is constant 0.

## Test plan
- Single event: rising edge on irq[3], rdata=32'h0000_00A5 at RD+1. Required: one read with addr=8'h4C; event id=3, data=32'hA5; write addr=8'h0C with wdata=1 (with the macro).
- Priority: edges on irq[7] and irq[2] in the same cycle. Required: channel 2 serviced first, then channel 7, with no ovr pulse.
- Backpressure: evt_ready held low 10 cycles. Required: evt_valid, evt_id and evt_data stable; no cs activity until the handshake.
- Overrun: two edges on irq[5] before its RD. Required: ovr[5] pulses once and only one event is produced. An edge on irq[5] after its RD produces a second event.
- Reset in WAIT with RD_LAT=3. Required: next cycle cs=0, evt_valid=0, busy=0, pend=0. Without CNT_IRQ_REARM_EN, no cycle ever shows cs=1 with rw=1.
